// File: rtl/glitch_seq_pkg.sv
// Shared types and helpers for the glitch sequencer.
// Holds the state enum, default widths and zero substitution.
package glitch_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_TRIG,
    DELAY,
    PULSE,
    GAP,
    DONE
  } state_t;

  localparam int DELAY_W_DEF   = 16;
  localparam int WIDTH_W_DEF   = 8;
  localparam int GAP_W_DEF     = 8;
  localparam int COUNT_W_DEF   = 4;
  localparam int TIMEOUT_W_DEF = 24;

  // A zero setting means "one" for width, gap and count.
  function automatic logic [31:0] nz1(input logic [31:0] v);
    return (v == 32'd0) ? 32'd1 : v;
  endfunction

endpackage

// File: rtl/seq_pulse_train.sv
// Pulse train generator: width-high, gap-low, count pulses.
// Started by a go strobe; o_last flags the final high cycle.
module seq_pulse_train
  import glitch_seq_pkg::*;
#(
  parameter int WIDTH_W = WIDTH_W_DEF,
  parameter int GAP_W   = GAP_W_DEF,
  parameter int COUNT_W = COUNT_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_go,
  input  logic               i_stop,
  input  logic [WIDTH_W-1:0] i_width,
  input  logic [GAP_W-1:0]   i_gap,
  input  logic [COUNT_W-1:0] i_count,
  output logic               o_glitch,
  output logic               o_last
);

  state_t             r_ph;
  logic               r_glitch;
  logic [WIDTH_W-1:0] r_wcnt;
  logic [GAP_W-1:0]   r_gcnt;
  logic [COUNT_W-1:0] r_pcnt;
  logic               w_wend;
  logic               w_gend;
  logic               w_pend;

  assign w_wend = (r_wcnt == i_width - WIDTH_W'(1));
  assign w_gend = (r_gcnt == i_gap - GAP_W'(1));
  assign w_pend = (r_pcnt == i_count - COUNT_W'(1));

  assign o_last   = (r_ph == PULSE) && w_wend && w_pend;
  assign o_glitch = r_glitch;

  // Walk PULSE/GAP phases and drive the registered glitch.
  always_ff @(posedge clk) begin
    if (rst || i_stop) begin
      r_ph     <= IDLE;
      r_glitch <= 1'b0;
      r_wcnt   <= '0;
      r_gcnt   <= '0;
      r_pcnt   <= '0;
    end else if (i_go) begin
      r_ph     <= PULSE;
      r_glitch <= 1'b1;
      r_wcnt   <= '0;
      r_gcnt   <= '0;
      r_pcnt   <= '0;
    end else begin
      case (r_ph)
        PULSE: begin
          if (w_wend) begin
            r_glitch <= 1'b0;
            r_wcnt   <= '0;
            r_gcnt   <= '0;
            if (w_pend) begin
              r_ph   <= IDLE;
              r_pcnt <= '0;
            end else begin
              r_ph   <= GAP;
              r_pcnt <= r_pcnt + COUNT_W'(1);
            end
          end else begin
            r_wcnt <= r_wcnt + WIDTH_W'(1);
          end
        end
        GAP: begin
          if (w_gend) begin
            r_ph     <= PULSE;
            r_glitch <= 1'b1;
            r_gcnt   <= '0;
            r_wcnt   <= '0;
          end else begin
            r_gcnt <= r_gcnt + GAP_W'(1);
          end
        end
        default: begin
          r_glitch <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/glitch_sequencer.sv
// Fault-injection sequencer: arm, wait trigger, delay, pulse train.
// Owns arming, delay, timeout, abort and done; train is a submodule.
module glitch_sequencer
  import glitch_seq_pkg::*;
#(
  parameter int DELAY_W   = DELAY_W_DEF,
  parameter int WIDTH_W   = WIDTH_W_DEF,
  parameter int GAP_W     = GAP_W_DEF,
  parameter int COUNT_W   = COUNT_W_DEF,
  parameter int TIMEOUT_W = TIMEOUT_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [DELAY_W-1:0]   cfg_delay,
  input  logic [WIDTH_W-1:0]   cfg_width,
  input  logic [GAP_W-1:0]     cfg_gap,
  input  logic [COUNT_W-1:0]   cfg_count,
  input  logic [TIMEOUT_W-1:0] cfg_timeout,
  output logic                 det_arm,
  input  logic                 det_trigger,
  output logic                 glitch,
  output logic                 busy,
  output logic                 done,
  output logic                 timed_out
);

  state_t               r_state;
  state_t               w_next;
  logic [DELAY_W-1:0]   r_delay;
  logic [WIDTH_W-1:0]   r_width;
  logic [GAP_W-1:0]     r_gap;
  logic [COUNT_W-1:0]   r_count;
  logic [TIMEOUT_W-1:0] r_timeout;
  logic [TIMEOUT_W-1:0] r_wait;
  logic [DELAY_W-1:0]   r_dly;
  logic                 r_arm;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_to;
  logic                 w_accept;
  logic                 w_to;
  logic                 w_go;
  logic                 w_kill;
  logic                 w_last;
  logic                 w_glitch;

  assign det_arm   = r_arm;
  assign glitch    = w_glitch;
  assign busy      = r_busy;
  assign done      = r_done;
  assign timed_out = r_to;

  assign w_kill = abort && (r_state != IDLE);

  // Next state; abort overrides every non-IDLE transition.
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_to     = 1'b0;
    case (r_state)
      IDLE: begin
        if (start && !det_trigger && !abort) begin
          w_next   = WAIT_TRIG;
          w_accept = 1'b1;
        end
      end
      WAIT_TRIG: begin
        if (det_trigger) begin
          w_next = (r_delay == '0) ? PULSE : DELAY;
        end else if (r_timeout != '0 &&
                     r_wait == r_timeout - TIMEOUT_W'(1)) begin
          w_next = DONE;
          w_to   = 1'b1;
        end
      end
      DELAY: begin
        if (r_dly == r_delay - DELAY_W'(1)) w_next = PULSE;
      end
      PULSE: begin
        if (w_last) w_next = DONE;
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
    if (w_kill) begin
      w_next = IDLE;
      w_to   = 1'b0;
    end
    w_go = (w_next == PULSE) && (r_state != PULSE);
  end

  // State, registered outputs and phase counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_arm   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_to    <= 1'b0;
      r_wait  <= '0;
      r_dly   <= '0;
    end else begin
      r_state <= w_next;
      r_arm   <= (w_next == WAIT_TRIG) || (w_next == DELAY) ||
                 (w_next == PULSE);
      r_busy  <= (w_next != IDLE);
      r_done  <= (w_next == DONE);
      r_to    <= w_to;
      if (r_state != w_next) begin
        r_wait <= '0;
        r_dly  <= '0;
      end else begin
        if (r_state == WAIT_TRIG && r_wait != '1)
          r_wait <= r_wait + TIMEOUT_W'(1);
        if (r_state == DELAY)
          r_dly <= r_dly + DELAY_W'(1);
      end
    end
  end

  // Shadow config captured on the accepted start edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_delay   <= '0;
      r_width   <= '0;
      r_gap     <= '0;
      r_count   <= '0;
      r_timeout <= '0;
    end else if (w_accept) begin
      r_delay   <= cfg_delay;
      r_width   <= WIDTH_W'(nz1(32'(cfg_width)));
      r_gap     <= GAP_W'(nz1(32'(cfg_gap)));
      r_count   <= COUNT_W'(nz1(32'(cfg_count)));
      r_timeout <= cfg_timeout;
    end
  end

  seq_pulse_train #(
    .WIDTH_W (WIDTH_W),
    .GAP_W   (GAP_W),
    .COUNT_W (COUNT_W)
  ) u_train (
    .clk      (clk),
    .rst      (rst),
    .i_go     (w_go),
    .i_stop   (w_kill),
    .i_width  (r_width),
    .i_gap    (r_gap),
    .i_count  (r_count),
    .o_glitch (w_glitch),
    .o_last   (w_last)
  );

endmodule

// File: tb/tb_glitch_sequencer.sv
// Randomized bench for glitch_sequencer against a timeline model.
// Model predicts each cycle's outputs from the sequence arithmetic.
module tb_glitch_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic [15:0] cfg_delay;
  logic [7:0]  cfg_width;
  logic [7:0]  cfg_gap;
  logic [3:0]  cfg_count;
  logic [23:0] cfg_timeout;
  logic        det_arm;
  logic        det_trigger;
  logic        glitch;
  logic        busy;
  logic        done;
  logic        timed_out;

  int n_tests = 0;
  int n_fail  = 0;
  int run_id  = 0;

  always #5 clk = ~clk;

  glitch_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
    .cfg_delay   (cfg_delay),
    .cfg_width   (cfg_width),
    .cfg_gap     (cfg_gap),
    .cfg_count   (cfg_count),
    .cfg_timeout (cfg_timeout),
    .det_arm     (det_arm),
    .det_trigger (det_trigger),
    .glitch      (glitch),
    .busy        (busy),
    .done        (done),
    .timed_out   (timed_out)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [4:0] outs();
    return {glitch, det_arm, busy, done, timed_out};
  endfunction

  function automatic bit tmo_hit(input int tmo, input int t);
    return (tmo != 0) && (t == 0 || t > tmo);
  endfunction

  // Cycle of the done pulse; start is sampled at the end of cycle 0.
  function automatic int fin_of(input int d, input int w, input int g,
                                input int c, input int tmo, input int t);
    int we, ge, ce;
    we = (w == 0) ? 1 : w;
    ge = (g == 0) ? 1 : g;
    ce = (c == 0) ? 1 : c;
    if (tmo_hit(tmo, t)) return 1 + tmo;
    if (t == 0) return 1 << 30;
    return t + 1 + d + ce * we + (ce - 1) * ge;
  endfunction

  // Expected {glitch, arm, busy, done, timed_out} in cycle k.
  function automatic logic [4:0] ref_out(input int k, input int d,
      input int w, input int g, input int c, input int tmo,
      input int t, input int kill);
    int we, ge, ce, fin, j;
    logic gl, arm, dn, to;
    we = (w == 0) ? 1 : w;
    ge = (g == 0) ? 1 : g;
    ce = (c == 0) ? 1 : c;
    if (k < 1) return 5'd0;
    if (kill > 0 && k > kill) return 5'd0;
    fin = fin_of(d, w, g, c, tmo, t);
    if (k > fin) return 5'd0;
    gl = 1'b0;
    if (!tmo_hit(tmo, t) && t > 0) begin
      j = k - (t + 1 + d);
      if (j >= 0)
        gl = ((j / (we + ge)) < ce) && ((j % (we + ge)) < we);
    end
    arm = (k < fin);
    dn  = (k == fin);
    to  = tmo_hit(tmo, t) && (k == fin);
    return {gl, arm, 1'b1, dn, to};
  endfunction

  // One sequence: start in cycle 0, trigger in cycle t (0 = none),
  // abort or reset in cycle kill (0 = none).
  task automatic run_seq(input int d, input int w, input int g,
      input int c, input int tmo, input int t, input int kill,
      input bit kill_rst);
    int fin, hz;
    fin = fin_of(d, w, g, c, tmo, t);
    if (fin > (1 << 29)) fin = kill;
    hz = fin;
    if (t > hz) hz = t;
    if (kill > hz) hz = kill;
    hz = hz + 3;
    run_id++;
    for (int k = 0; k <= hz; k++) begin
      @(negedge clk);
      chk($sformatf("run%0d cyc%0d", run_id, k), 32'(outs()),
          32'(ref_out(k, d, w, g, c, tmo, t, kill)));
      start = (k == 0);
      if (k == 0) begin
        cfg_delay   = 16'(d);
        cfg_width   = 8'(w);
        cfg_gap     = 8'(g);
        cfg_count   = 4'(c);
        cfg_timeout = 24'(tmo);
      end else begin
        cfg_delay   = 16'($urandom);
        cfg_width   = 8'($urandom);
        cfg_gap     = 8'($urandom);
        cfg_count   = 4'($urandom);
        cfg_timeout = 24'($urandom);
      end
      if (t > 0 && k == t) det_trigger = 1'b1;
      else if (t > 0 && k > t && k < hz - 1)
        det_trigger = 1'($urandom % 2);
      else det_trigger = 1'b0;
      abort = (kill > 0 && k == kill && !kill_rst);
      rst   = (kill > 0 && k == kill && kill_rst);
    end
  endtask

  initial begin
    int d, w, g, c, tmo, t, kill, fin;
    bit kr;
    rst = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    det_trigger = 1'b0;
    cfg_delay = '0;
    cfg_width = '0;
    cfg_gap = '0;
    cfg_count = '0;
    cfg_timeout = '0;
    repeat (2) @(negedge clk);
    chk("reset_outs", 32'(outs()), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_outs", 32'(outs()), 32'd0);

    start = 1'b1;
    det_trigger = 1'b1;
    @(negedge clk);
    chk("rearm_guard", 32'(outs()), 32'd0);
    start = 1'b0;
    det_trigger = 1'b0;
    @(negedge clk);
    chk("rearm_guard_hold", 32'(outs()), 32'd0);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    chk("abort_beats_start", 32'(outs()), 32'd0);
    start = 1'b0;
    abort = 1'b0;

    run_seq(3, 2, 0, 1, 0, 10, 0, 1'b0);
    run_seq(0, 1, 2, 3, 0, 5, 0, 1'b0);
    run_seq(0, 1, 1, 1, 20, 0, 0, 1'b0);
    run_seq(0, 1, 1, 1, 20, 20, 0, 1'b0);
    run_seq(0, 1, 1, 1, 0, 0, 1000, 1'b0);
    run_seq(2, 3, 2, 4, 0, 4, 13, 1'b0);
    run_seq(3, 2, 0, 1, 0, 10, 0, 1'b0);
    run_seq(2, 0, 0, 0, 0, 3, 0, 1'b0);
    run_seq(1, 4, 1, 2, 0, 3, 6, 1'b1);
    run_seq(0, 1, 0, 15, 0, 2, 0, 1'b0);
    run_seq(5, 1, 1, 1, 1, 1, 0, 1'b0);
    run_seq(5, 1, 1, 1, 1, 0, 0, 1'b0);

    for (int i = 0; i < 60; i++) begin
      d    = ($urandom % 3 == 0) ? 0 : int'($urandom % 12);
      w    = int'($urandom % 5);
      g    = int'($urandom % 5);
      c    = int'($urandom % 6);
      tmo  = ($urandom % 3 == 0) ? 1 + int'($urandom % 25) : 0;
      t    = 1 + int'($urandom % 30);
      fin  = fin_of(d, w, g, c, tmo, t);
      kill = ($urandom % 4 == 0) ? 1 + int'($urandom % (fin + 1)) : 0;
      kr   = 1'($urandom % 2);
      run_seq(d, w, g, c, tmo, t, kill, kr);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/glitch_sequencer.md
Name: glitch_sequencer

Overview:
- Controller that sequences one edge-detector block and a glitch output for a fault-injection campaign.
- On start it latches a configuration, arms the detector and waits for its trigger (with optional timeout).
- After the trigger it counts a programmable delay, then emits a train of glitch pulses with programmable width, count and gap.
- Sits between the host/config logic and the detector + glitch driver.

Parameters:
DELAY_W, 16, width of cfg_delay (cycles from trigger to first pulse)
WIDTH_W, 8, width of cfg_width (glitch pulse high time, cycles)
GAP_W, 8, width of cfg_gap (low time between pulses, cycles)
COUNT_W, 4, width of cfg_count (number of pulses)
TIMEOUT_W, 24, width of cfg_timeout (max cycles waiting for trigger; 0 = no timeout)

Ports:
clk  input  1  clock
rst  input  1  synchronous, active-high reset
start  input  1  begin a sequence (sampled in IDLE only)
abort  input  1  cancel any sequence in progress
cfg_delay  input  DELAY_W  trigger-to-first-pulse delay
cfg_width  input  WIDTH_W  pulse width; 0 treated as 1
cfg_gap  input  GAP_W  inter-pulse gap; 0 treated as 1
cfg_count  input  COUNT_W  pulse count; 0 treated as 1
cfg_timeout  input  TIMEOUT_W  trigger wait limit; 0 = wait forever
det_arm  output  1  arm signal to the detector
det_trigger  input  1  trigger from the detector
glitch  output  1  glitch drive, registered
busy  output  1  high in every non-IDLE state
done  output  1  one-cycle pulse at normal completion or timeout
timed_out  output  1  qualifies done; high only in the done cycle of a timeout

Behaviour:
- Reset: state IDLE; det_arm, glitch, busy, done and timed_out = 0; all counters 0. Reset mid-sequence drops glitch and det_arm on the next edge.
- All outputs are registered. cfg_* are latched into shadow registers on the accepted start edge; later cfg changes do not affect a running sequence.

States:
- IDLE: start=1 and det_trigger=0 -> WAIT_TRIG, det_arm<=1. start while det_trigger=1 is ignored, so the detector observes arm low before re-arming.
- WAIT_TRIG: wait counter increments each cycle.
  - det_trigger=1 sampled in cycle T -> DELAY, or directly to PULSE if delay=0.
  - If timeout!=0 and the wait counter reaches timeout with no trigger -> DONE with timed_out.
  - If the trigger and timeout expiry occur in the same cycle, the trigger wins.
- DELAY: counts delay cycles. glitch is first high in cycle T+1+delay.
- PULSE: glitch high for exactly width cycles.
  - Pulses remaining -> GAP.
  - Last pulse -> DONE.
- GAP: glitch low for exactly gap cycles -> PULSE.
- DONE: exactly one cycle. done=1, det_arm=0, glitch=0, busy=1 -> IDLE.
- abort: highest priority, in any non-IDLE state. Next cycle: IDLE, glitch=0, det_arm=0, no done pulse. In IDLE, abort is ignored, and abort wins over a same-cycle start.

Timing:
- Total glitch-high cycles = count*width.
- done occurs in the cycle after the last glitch-high cycle; busy is low the cycle after done.
- Counters compare against the latched values with zero-substitution applied. No counter wraps: each counter is sized to its cfg field and cleared on every state entry.

Decomposition:
- Package glitch_seq_pkg holds:
  - state enum (IDLE, WAIT_TRIG, DELAY, PULSE, GAP, DONE)
  - default width localparams
  - zero-to-one substitution function
- Sub-module seq_pulse_train owns PULSE/GAP and pulse counting. Interface: go in; width/gap/count in; glitch out; last out. The top module owns arming, delay, timeout, abort and done.

Test Plan:
- Basic sequence: delay=3, width=2, count=1, trigger in cycle 10 -> glitch high in cycles 14-15, done in 16, busy low in 17, det_arm low from 16.
- Pulse train: delay=0, width=1, gap=2, count=3, trigger in cycle 5 -> glitch high in cycles 6, 9, 12; done in 13.
- Timeout: timeout=20, no trigger -> done=1 and timed_out=1 exactly 20 cycles after WAIT_TRIG entry. Repeat with timeout=0 and no trigger for 1000 cycles -> remains busy.
- Abort: abort during the second pulse of count=4 -> glitch 0 and det_arm 0 next cycle, no done, IDLE. A new start then behaves like the basic sequence.
- Zero config and cfg latching: width=0, gap=0, count=0 -> single one-cycle pulse. Changing cfg_delay mid-sequence has no effect.
- Re-arm guard: start while det_trigger=1 is ignored. Assert rst during PULSE -> glitch low next edge, all outputs at reset values.
